// File: rtl/decoder_pkg.sv
// Shared encodings for the registered select-line decoder family:
// input mode codes and controller state labels.
package decoder_pkg;

    localparam logic [1:0] MODE_ONEHOT = 2'd0;
    localparam logic [1:0] MODE_THERM  = 2'd1;
    localparam logic [1:0] MODE_SCAN   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_nx_seq_dwell_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while enabled and pulses
// tick in the cycle the count sits at DWELL-1 (the counter then wraps to 0).
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(DWELL - 1);

    logic [15:0] cnt_q;

    assign tick = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/decoder_nx_seq.sv
// Registered SEL_W-to-2^SEL_W decoder with valid/ready input, one-hot or
// thermometer direct decode, and an autonomous one-hot scan with dwell.
module decoder_nx_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int OUT_W     = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic [SEL_W-1:0] scan_idx
);

    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

    function automatic logic [OUT_W-1:0] dec_onehot(input logic [SEL_W-1:0] s);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] dec_therm(input logic [SEL_W-1:0] s);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_W; i++) begin
            v[i] = (i <= int'(s));
        end
        return v;
    endfunction

    state_e           state_q;
    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [SEL_W-1:0] scan_idx_q;
    logic             last_therm_q;

    logic             to_scan;
    logic             xfer;
    logic             use_therm;
    logic             stay_scan;
    logic             dwell_tick;
    logic [SEL_W-1:0] scan_idx_d;
    logic [OUT_W-1:0] direct_d;

    assign to_scan    = (mode == MODE_SCAN);
    assign xfer       = en && (state_q == DIRECT) && in_ready_q && in_valid;
    assign stay_scan  = en && (state_q == SCAN) && to_scan;
    assign scan_idx_d = scan_idx_q + 1'b1;

    // A transfer racing a switch into scan still decodes with the last direct mode.
    assign use_therm = to_scan ? last_therm_q : (mode == MODE_THERM);
    assign direct_d  = use_therm ? dec_therm(sel) : dec_onehot(sel);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (!stay_scan),
        .en   (stay_scan),
        .tick (dwell_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            out_q        <= INACTIVE;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            scan_idx_q   <= '0;
            last_therm_q <= 1'b0;
        end else begin
            if (!to_scan) begin
                last_therm_q <= (mode == MODE_THERM);
            end
            if (!en) begin
                state_q     <= IDLE;
                out_q       <= INACTIVE;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b0;
                scan_idx_q  <= '0;
            end else if (xfer) begin
                // Stay in DIRECT this edge; a pending scan request is taken next edge.
                out_q       <= direct_d ^ INACTIVE;
                out_valid_q <= 1'b1;
                in_ready_q  <= !to_scan;
            end else if (to_scan) begin
                in_ready_q <= 1'b0;
                if (state_q != SCAN) begin
                    state_q     <= SCAN;
                    out_q       <= dec_onehot({SEL_W{1'b0}}) ^ INACTIVE;
                    out_valid_q <= 1'b1;
                    scan_idx_q  <= '0;
                end else if (dwell_tick) begin
                    scan_idx_q <= scan_idx_d;
                    out_q      <= dec_onehot(scan_idx_d) ^ INACTIVE;
                end
            end else if (state_q != DIRECT) begin
                state_q     <= DIRECT;
                out_q       <= INACTIVE;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
                scan_idx_q  <= '0;
            end else begin
                in_ready_q <= 1'b1;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign scan_idx  = scan_idx_q;

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Directed bench for decoder_nx_seq: default instance (3/4/0) plus a
// 4-bit, DWELL=1, active-low instance sharing clock and reset.
module tb_decoder_nx_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        en, in_valid, in_ready, out_valid;
    logic [1:0]  mode;
    logic [2:0]  sel, scan_idx;
    logic [7:0]  out;

    logic        b_en, b_in_valid, b_in_ready, b_out_valid;
    logic [1:0]  b_mode;
    logic [3:0]  b_sel, b_scan_idx;
    logic [15:0] b_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_nx_seq #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out(out), .out_valid(out_valid),
        .scan_idx(scan_idx)
    );

    decoder_nx_seq #(.SEL_W(4), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out(b_out), .out_valid(b_out_valid),
        .scan_idx(b_scan_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s observed %0h expected %0h ok", tag, obs, exp);
        end else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        rst = 1'b1; en = 1'b0; mode = 2'd0; in_valid = 1'b0; sel = 3'd0;
        b_en = 1'b0; b_mode = 2'd0; b_in_valid = 1'b0; b_sel = 4'd0;
        cyc(); cyc();
        check("rst_out", 32'(out), 32'h00);
        check("rst_b_out", 32'(b_out), 32'hFFFF);
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);

        en = 1'b1; mode = 2'd0;
        cyc();
        check("dir_ready", 32'(in_ready), 32'd1);
        check("dir_valid0", 32'(out_valid), 32'd0);
        in_valid = 1'b1; sel = 3'd3;
        cyc();
        in_valid = 1'b0;
        check("oh_sel3", 32'(out), 32'h08);

        // Reset asserted mid-cycle must clear outputs without an edge.
        #2 rst = 1'b1;
        #1;
        check("arst_out", 32'(out), 32'h00);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        cyc();
        check("re_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; sel = 3'd5;
        cyc();
        check("oh_sel5", 32'(out), 32'h20);
        check("oh_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; sel = 3'd1;
        cyc();
        check("hold_out", 32'(out), 32'h20);
        check("hold_valid", 32'(out_valid), 32'd1);

        mode = 2'd1; in_valid = 1'b1; sel = 3'd0;
        cyc();
        check("th_sel0", 32'(out), 32'h01);
        sel = 3'd3;
        cyc();
        check("th_sel3", 32'(out), 32'h0F);
        check("th_ready", 32'(in_ready), 32'd1);
        sel = 3'd7;
        cyc();
        check("th_sel7", 32'(out), 32'hFF);
        in_valid = 1'b0;

        mode = 2'd2;
        cyc();
        check("scan_entry", 32'(out), 32'h01);
        check("scan_valid", 32'(out_valid), 32'd1);
        check("scan_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k <= 44; k++) begin
            in_valid = k[0];
            sel = 3'(k * 3);
            cyc();
            idx = (k / 4) % 8;
            check($sformatf("scan_k%0d", k), 32'(out), 32'(8'h01 << idx));
            check("scan_idx", 32'(scan_idx), 32'(idx));
            check("scan_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        en = 1'b0;
        cyc();
        check("endrop_out", 32'(out), 32'h00);
        check("endrop_valid", 32'(out_valid), 32'd0);
        check("endrop_idx", 32'(scan_idx), 32'd0);
        en = 1'b1;
        cyc();
        check("rescan_out", 32'(out), 32'h01);
        check("rescan_idx", 32'(scan_idx), 32'd0);

        mode = 2'd0;
        cyc();
        check("back_ready", 32'(in_ready), 32'd1);
        check("back_valid", 32'(out_valid), 32'd0);
        check("back_out", 32'(out), 32'h00);
        in_valid = 1'b1; sel = 3'd1;
        cyc();
        check("pre_sel1", 32'(out), 32'h02);
        sel = 3'd2; en = 1'b0;
        cyc();
        check("enfall_out", 32'(out), 32'h00);
        check("enfall_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0; en = 1'b1;
        cyc();
        check("en_ready", 32'(in_ready), 32'd1);

        in_valid = 1'b1; sel = 3'd6; mode = 2'd2;
        cyc();
        check("race_out", 32'(out), 32'h40);
        check("race_valid", 32'(out_valid), 32'd1);
        cyc();
        check("race_scan", 32'(out), 32'h01);
        check("race_scidx", 32'(scan_idx), 32'd0);
        in_valid = 1'b0;

        mode = 2'd3;
        cyc();
        check("m3_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; sel = 3'd4;
        cyc();
        check("m3_onehot", 32'(out), 32'h10);
        in_valid = 1'b0;

        b_en = 1'b1; b_mode = 2'd2;
        cyc();
        check("b_scan0", 32'(b_out), 32'hFFFE);
        cyc();
        check("b_scan1", 32'(b_out), 32'hFFFD);
        cyc();
        check("b_scan2", 32'(b_out), 32'hFFFB);
        check("b_idx2", 32'(b_scan_idx), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("b_arst", 32'(b_out), 32'hFFFF);
        check("b_arst_val", 32'(b_out_valid), 32'd0);
        rst = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
